// File: rtl/dm_responder.sv
// dm_responder: data-memory target for the CPU MEM stage load/store interface.
// After reset, writes zero to the whole array, one word per cycle. It then accepts
// one word-addressed read or write at a time. Each request completes LATENCY edges
// after it is accepted, with a one-cycle ready pulse.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   req    in   request valid, held with all fields until ready
//   we     in   1 = write, 0 = read
//   addr   in   byte address, bits [1:0] ignored
//   wdata  in   lane-aligned write data
//   be     in   byte enables, writes only
//   rdata  out  read word, held until the next response
//   ready  out  one-cycle completion pulse
//   err    out  out-of-range flag, valid with ready
//   busy   out  low only while idle
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned IW      = $clog2(DEPTH_WORDS);
    localparam int unsigned CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {StClear, StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   clr_idx_q, clr_idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lat_we_q;
    logic [IW-1:0]   lat_idx_q;
    logic [31:0]     lat_wdata_q;
    logic [3:0]      lat_be_q;
    logic            lat_oor_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem [DEPTH_WORDS];

    // The 33-bit offset goes negative (bit 32 set) when addr is below the base.
    logic [32:0]     offset;
    logic            req_oor;
    logic [IW-1:0]   req_idx;

    assign offset  = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign req_oor = offset[32] | (offset >= SPAN);
    assign req_idx = offset[IW+1:2];

    // When LATENCY = 1, the access happens on the accepting edge itself, so it
    // uses the live request fields instead of the latched copy.
    logic            acc_we;
    logic [IW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic            acc_oor;
    logic            enter_resp;

    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = we;
            acc_idx   = req_idx;
            acc_wdata = wdata;
            acc_be    = be;
            acc_oor   = req_oor;
        end else begin
            acc_we    = lat_we_q;
            acc_idx   = lat_idx_q;
            acc_wdata = lat_wdata_q;
            acc_be    = lat_be_q;
            acc_oor   = lat_oor_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IW'(DEPTH_WORDS - 1)) state_d = StIdle;
            end
            StIdle: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StClear;
            clr_idx_q   <= '0;
            cnt_q       <= '0;
            lat_we_q    <= 1'b0;
            lat_idx_q   <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
            lat_oor_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            cnt_q     <= cnt_d;
            if (state_q == StIdle && req) begin
                lat_we_q    <= we;
                lat_idx_q   <= req_idx;
                lat_wdata_q <= wdata;
                lat_be_q    <= be;
                lat_oor_q   <= req_oor;
            end
            if (enter_resp) begin
                err_q <= acc_oor;
                if (acc_oor)      rdata_q <= '0;
                else if (!acc_we) rdata_q <= mem[acc_idx];
            end
        end
    end

    // The array has no reset. Writes are blocked while reset is held, so an
    // in-flight request is never committed.
    logic            mem_we;
    logic [IW-1:0]   mem_idx;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_be;

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = acc_idx;
        mem_wdata = acc_wdata;
        mem_be    = acc_be;
        if (state_q == StClear) begin
            mem_we    = !reset;
            mem_idx   = clr_idx_q;
            mem_wdata = '0;
            mem_be    = 4'hF;
        end else if (enter_resp && acc_we && !acc_oor) begin
            mem_we = !reset;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = (state_q == StResp);
    assign err   = (state_q == StResp) & err_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_dm_responder.sv
// Testbench for dm_responder. Two instances share one clock: index 0 has
// LATENCY = 2 and index 1 has LATENCY = 1. A timestamp-based reference model
// predicts busy, ready, err and rdata for every cycle.
module tb_dm_responder;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];

    int checks = 0;
    int errors = 0;

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut_l2 (
        .clk(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .ready(ready[0]),
        .err(err[0]), .busy(busy[0])
    );

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut_l1 (
        .clk(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .ready(ready[1]),
        .err(err[1]), .busy(busy[1])
    );

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model. e = clock edges since reset was released, so cycle e is
    // the interval after edge e. An accept in cycle e gives ready in cycle
    // e+LAT. The unit is idle again from cycle e+LAT+1.
    logic [31:0] mm [2][DEPTH];
    int          e      [2];
    int          free_c [2];
    int          resp_c [2];
    bit          pend   [2];
    bit          p_we   [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd   [2];
    logic [3:0]  p_be   [2];
    logic [31:0] m_rd   [2];
    bit          m_err  [2];

    task automatic model_apply(int i);
        longint a;
        int     idx;
        bit     oor;
        a   = longint'(p_addr[i]);
        oor = (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * longint'(DEPTH));
        m_err[i] = oor;
        if (oor) begin
            m_rd[i] = 32'h0;
        end else begin
            idx = int'((a - longint'(BASE)) / 4);
            if (p_we[i]) begin
                for (int k = 0; k < 4; k++)
                    if (p_be[i][k]) mm[i][idx][8*k +: 8] = p_wd[i][8*k +: 8];
            end else begin
                m_rd[i] = mm[i][idx];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst[i]) begin
                    e[i] = 0; free_c[i] = DEPTH; pend[i] = 0; m_rd[i] = 0; m_err[i] = 0;
                    resp_c[i] = -1;
                    for (int w = 0; w < DEPTH; w++) mm[i][w] = 32'h0;
                end else begin
                    if (e[i] >= free_c[i] && req[i]) begin
                        resp_c[i] = e[i] + lat_of(i);
                        free_c[i] = resp_c[i] + 1;
                        pend[i]   = 1;
                        p_we[i]   = we[i];
                        p_addr[i] = addr[i];
                        p_wd[i]   = wdata[i];
                        p_be[i]   = be[i];
                    end
                    e[i]++;
                    if (pend[i] && e[i] == resp_c[i]) model_apply(i);
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial begin
        bit exp_ready;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst[i]) begin
                    check($sformatf("reset busy[%0d]", i), 32'(busy[i]), 32'd1);
                    check($sformatf("reset ready[%0d]", i), 32'(ready[i]), 32'd0);
                    check($sformatf("reset err[%0d]", i), 32'(err[i]), 32'd0);
                    check($sformatf("reset rdata[%0d]", i), rdata[i], 32'h0);
                end else begin
                    exp_ready = pend[i] && (e[i] == resp_c[i]);
                    check($sformatf("busy[%0d] cyc %0d", i, e[i]), 32'(busy[i]),
                          32'(e[i] < free_c[i]));
                    check($sformatf("ready[%0d] cyc %0d", i, e[i]), 32'(ready[i]),
                          32'(exp_ready));
                    check($sformatf("err[%0d] cyc %0d", i, e[i]), 32'(err[i]),
                          32'(exp_ready && m_err[i]));
                    check($sformatf("rdata[%0d] cyc %0d", i, e[i]), rdata[i], m_rd[i]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an idle cycle. Returns in the idle cycle after ready, with req
    // still high, so the caller can chain another request immediately.
    task automatic do_req(int i, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b,
                          string name, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        check({name, " idle at accept"}, 32'(busy[i]), 32'd0);
        we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b; req[i] = 1'b1;
        do begin
            step();
            n++;
        end while (!ready[i] && n < 20);
        check({name, " latency"}, 32'(n), 32'(lat_of(i)));
        rd = rdata[i];
        er = err[i];
        step();
    endtask

    // Counts busy cycles after reset release. Optionally pokes req to show that
    // requests are ignored during the clear sweep.
    task automatic sweep(int i, bit poke, string name);
        int n;
        n = 0;
        while (busy[i] && n < 5000) begin
            if (poke && n == 100) begin
                we[i] = 1'b1; addr[i] = 32'h0; wdata[i] = 32'hBAD0_BAD0; be[i] = 4'hF;
                req[i] = 1'b1;
            end
            if (poke && n == 110) req[i] = 1'b0;
            n++;
            step();
        end
        check({name, " busy cycles"}, 32'(n), 32'(DEPTH));
    endtask

    logic [31:0] rd;
    logic        er;
    int          pulses;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
            addr[i] = 32'h0; wdata[i] = 32'h0; be[i] = 4'h0;
        end
        repeat (3) step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        sweep(0, 1'b1, "clear0");

        do_req(0, 0, 32'h0000_0FFC, 32'h0, 4'h0, "rd ffc", rd, er);
        check("rd ffc data", rd, 32'h0);
        check("rd ffc err", 32'(er), 32'd0);
        do_req(0, 0, 32'h0, 32'h0, 4'h0, "rd 0 after poke", rd, er);
        check("poke ignored", rd, 32'h0);
        req[0] = 1'b0;
        step();

        do_req(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr 10 full", rd, er);
        check("wr 10 err", 32'(er), 32'd0);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, "rd 10 a", rd, er);
        check("rd 10 full", rd, 32'hDEAD_BEEF);
        check("rd 10 err", 32'(er), 32'd0);
        do_req(0, 1, 32'h10, 32'h0000_00AA, 4'b0001, "wr 10 lane0", rd, er);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, "rd 10 b", rd, er);
        check("rd 10 lane0", rd, 32'hDEAD_BEAA);
        do_req(0, 1, 32'h10, 32'h5566_0000, 4'b1100, "wr 10 upper", rd, er);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, "rd 10 c", rd, er);
        check("rd 10 upper", rd, 32'h5566_BEAA);
        do_req(0, 1, 32'h10, 32'h1111_1111, 4'b0000, "wr 10 no lanes", rd, er);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, "rd 10 d", rd, er);
        check("rd 10 be0", rd, 32'h5566_BEAA);

        do_req(0, 1, 32'h0, 32'hCAFE_F00D, 4'hF, "wr 0", rd, er);
        do_req(0, 0, 32'h0000_4000, 32'h0, 4'h0, "rd oor", rd, er);
        check("rd oor err", 32'(er), 32'd1);
        check("rd oor data", rd, 32'h0);
        do_req(0, 1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 4'hF, "wr oor", rd, er);
        check("wr oor err", 32'(er), 32'd1);
        do_req(0, 0, 32'h0, 32'h0, 4'h0, "rd 0", rd, er);
        check("rd 0 intact", rd, 32'hCAFE_F00D);
        check("rd 0 err", 32'(er), 32'd0);
        req[0] = 1'b0;
        step();

        // Back-to-back requests with req held high on both latencies.
        for (int i = 0; i < 2; i++) begin
            do_req(i, 1, 32'h100, 32'h1111_2222, 4'hF, $sformatf("b2b%0d w100", i), rd, er);
            do_req(i, 0, 32'h100, 32'h0, 4'h0, $sformatf("b2b%0d r100", i), rd, er);
            check($sformatf("b2b%0d r100 data", i), rd, 32'h1111_2222);
            do_req(i, 1, 32'h104, 32'h3333_4444, 4'hF, $sformatf("b2b%0d w104", i), rd, er);
            do_req(i, 0, 32'h104, 32'h0, 4'h0, $sformatf("b2b%0d r104", i), rd, er);
            check($sformatf("b2b%0d r104 data", i), rd, 32'h3333_4444);
            do_req(i, 0, 32'h100, 32'h0, 4'h0, $sformatf("b2b%0d r100b", i), rd, er);
            check($sformatf("b2b%0d r100b data", i), rd, 32'h1111_2222);
            req[i] = 1'b0;
            step();
        end

        // Reset while a write waits: it must never commit or respond.
        we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
        req[0] = 1'b1;
        step();
        rst[0] = 1'b1;
        pulses = 0;
        repeat (3) begin
            step();
            if (ready[0]) pulses++;
        end
        check("reset in wait pulses", 32'(pulses), 32'd0);
        req[0] = 1'b0;
        rst[0] = 1'b0;
        sweep(0, 1'b0, "clear1");
        do_req(0, 0, 32'h20, 32'h0, 4'h0, "rd 20 after reset", rd, er);
        check("rd 20 cleared", rd, 32'h0);
        do_req(0, 0, 32'h10, 32'h0, 4'h0, "rd 10 after reset", rd, er);
        check("rd 10 cleared", rd, 32'h0);
        req[0] = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the target end of the load/store request interface driven by the pipelined CPU's MEM stage.
- Accepts one word-addressed read or write per request, with byte-lane write enables.
- Completes each request after a fixed, parameterised latency and signals completion with a one-cycle ready pulse. The MEM stage stalls until it sees that pulse.
- After reset, sweeps the whole array to zero before it accepts any request.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; a power of two, >= 2.
- LATENCY, 2: edges from request acceptance to ready; >= 1.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request valid; requester holds it and all request fields stable until ready.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address; bits [1:0] are ignored.
- wdata  in  32  write data, lane-aligned (byte k on bits 8k+7:8k).
- be  in  4  byte enables for writes; ignored on reads.
- rdata  out  32  full read word; valid while ready is high, then held until the next response.
- ready  out  1  one-cycle completion pulse.
- err  out  1  high with ready when the address was out of range.
- busy  out  1  high while clearing, waiting or responding; low only in IDLE.

Behaviour:
- Reset (asynchronous, any state) forces:
  - state = CLEAR, clear index = 0;
  - rdata = 0, ready = 0, err = 0, busy = 1;
  - any in-flight request is discarded; an uncommitted write is never performed.
- CLEAR state:
  - writes 0 to one word per cycle at the clear index, then increments the index;
  - after the word DEPTH_WORDS-1 is written, goes to IDLE. Total: exactly DEPTH_WORDS cycles after reset deasserts;
  - req is ignored throughout CLEAR.
- IDLE state:
  - busy = 0;
  - on an edge with req = 1, latch we, word index = (addr - BASE_ADDR) >> 2, wdata and be, plus an out-of-range flag;
  - out of range means addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS;
  - then go to WAIT with counter = LATENCY-1, or straight to RESP when LATENCY = 1.
- WAIT state:
  - counter decrements each edge;
  - on the edge where the counter is 1, go to RESP.
- Access: performed on the edge that enters RESP.
  - Write: update only the lanes with be[k] = 1; other lanes keep their value.
  - Read: register mem[index] into rdata.
  - Out-of-range request: no array access, rdata = 0, err = 1.
  - Write response: rdata keeps its previous value.
- RESP state:
  - ready = 1 for exactly one cycle; err is valid in the same cycle;
  - the next edge goes to IDLE unconditionally.
- Request timing rules:
  - the requester may change or drop req only in the cycle after ready;
  - a req still high in that IDLE cycle is taken as a new request;
  - req asserted while busy is not queued; it is sampled only in IDLE.
- Latency: ready rises exactly LATENCY cycles after the accepting edge. A request accepted back-to-back completes every LATENCY+1 cycles.
- Write with be = 4'b0000: completes normally with no array change.
- Read-after-write to the same word in consecutive requests returns the merged new data.
- Reset in RESP drops the pulse immediately.

Test Plan:
- Reset 3 cycles, release -> busy high for exactly 4096 cycles; any req during this window is ignored; then a read of 0x0000_0FFC returns 0 with ready on the LATENCY-th edge.
- Write addr 0x10, wdata 0xDEADBEEF, be 4'b1111, then read 0x10 -> rdata 0xDEADBEEF, err 0; ready pulses exactly 1 cycle, 2 cycles after each accept (LATENCY = 2).
- Write 0x10, wdata 0x000000AA, be 4'b0001, then read 0x10 -> 0xDEADBEAA. Write wdata 0x55660000, be 4'b1100 -> read returns 0x5566BEAA.
- Read addr 0x0000_4000 (one past the end), and write 0xFFFF_FFFC -> both complete with ready and err = 1; rdata = 0 on the read; the array is unchanged (read 0x0 still returns its prior value).
- Assert reset in WAIT during a write to 0x20 (wdata 0x12345678) -> ready never pulses; after the clear sweep, read 0x20 returns 0.
- Hold req high continuously with alternating requests changed in the cycle after each ready -> one completion every 3 cycles; no request is lost or duplicated; busy is low exactly in each accepting cycle. Repeat with LATENCY = 1: completions every 2 cycles.
